// File: rtl/ysyx_rob_pkg.sv
// Shared constants, entry layout and tag helpers for the reorder buffer.
// Tag 0 means "no dependency"; tags 1..ROB_SIZE name entries 0..ROB_SIZE-1.
package ysyx_rob_pkg;

    localparam int unsigned XLEN     = 32;
    localparam int unsigned ROB_SIZE = 4;
    localparam int unsigned IDXW     = $clog2(ROB_SIZE);
    localparam int unsigned TAGW     = IDXW + 1;
    localparam int unsigned CNTW     = IDXW + 1;

    typedef struct packed {
        logic            busy;
        logic            done;
        logic [4:0]      rd;
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] result;
        logic [XLEN-1:0] npc;
        logic            pc_change;
        logic            csr_wen;
        logic [11:0]     csr_addr;
        logic [XLEN-1:0] csr_wdata;
        logic            ecall;
        logic            mret;
        logic            ebreak;
    } rob_entry_t;

    function automatic logic [IDXW-1:0] tag_to_idx(input logic [TAGW-1:0] tag);
        return IDXW'(tag - TAGW'(1));
    endfunction

    // Tags above ROB_SIZE would alias after truncation, so they never match.
    function automatic logic tag_in_range(input logic [TAGW-1:0] tag);
        return (tag != '0) && (tag <= TAGW'(ROB_SIZE));
    endfunction

endpackage

// File: rtl/ysyx_rob.sv
// In-order reorder buffer: allocates tags, captures out-of-order writebacks,
// forwards completed results and retires the head entry, flushing on redirect.
module ysyx_rob
    import ysyx_rob_pkg::*;
(
    input  logic            clock,
    input  logic            reset,
    input  logic            alloc_valid,
    input  logic [4:0]      alloc_rd,
    input  logic [XLEN-1:0] alloc_pc,
    output logic            alloc_ready,
    output logic [TAGW-1:0] alloc_tag,
    input  logic            wb_valid,
    input  logic [TAGW-1:0] wb_dest,
    input  logic [XLEN-1:0] wb_result,
    input  logic [XLEN-1:0] wb_npc,
    input  logic            wb_pc_change,
    input  logic            wb_ebreak,
    input  logic            wb_ecall,
    input  logic            wb_mret,
    input  logic            wb_csr_wen,
    input  logic [11:0]     wb_csr_addr,
    input  logic [XLEN-1:0] wb_csr_wdata,
    input  logic [TAGW-1:0] qj_tag,
    input  logic [TAGW-1:0] qk_tag,
    output logic            qj_ready,
    output logic            qk_ready,
    output logic [XLEN-1:0] qj_value,
    output logic [XLEN-1:0] qk_value,
    output logic            commit_valid,
    output logic [4:0]      commit_rd,
    output logic [XLEN-1:0] commit_pc,
    output logic [XLEN-1:0] commit_result,
    output logic            commit_csr_wen,
    output logic [11:0]     commit_csr_addr,
    output logic [XLEN-1:0] commit_csr_wdata,
    output logic            commit_ecall,
    output logic            commit_mret,
    output logic            commit_ebreak,
    output logic            flush_pipeline,
    output logic [XLEN-1:0] flush_npc
);

    rob_entry_t      rob_q [ROB_SIZE];
    logic [IDXW-1:0] head_q;
    logic [IDXW-1:0] tail_q;
    logic [CNTW-1:0] count_q;

    rob_entry_t      head_e;
    logic [IDXW-1:0] wb_idx;
    logic            wb_hit;
    logic            alloc_fire;

    assign head_e      = rob_q[head_q];
    assign alloc_ready = (count_q != CNTW'(ROB_SIZE));
    assign alloc_tag   = TAGW'(tail_q) + TAGW'(1);

    // Head retirement and redirect decode
    assign commit_valid     = head_e.busy && head_e.done;
    assign commit_rd        = head_e.rd;
    assign commit_pc        = head_e.pc;
    assign commit_result    = head_e.result;
    assign commit_csr_wen   = head_e.csr_wen;
    assign commit_csr_addr  = head_e.csr_addr;
    assign commit_csr_wdata = head_e.csr_wdata;
    assign commit_ecall     = head_e.ecall;
    assign commit_mret      = head_e.mret;
    assign commit_ebreak    = head_e.ebreak;
    assign flush_pipeline   = commit_valid && (head_e.pc_change || head_e.ecall || head_e.mret);
    assign flush_npc        = head_e.npc;

    assign alloc_fire = alloc_valid && alloc_ready && !flush_pipeline;
    assign wb_idx     = tag_to_idx(wb_dest);
    assign wb_hit     = wb_valid && tag_in_range(wb_dest)
                        && rob_q[wb_idx].busy && !rob_q[wb_idx].done;

    // Operand lookup: same-cycle writeback bypass takes priority over storage
    always_comb begin
        qj_ready = 1'b0;
        qj_value = '0;
        qk_ready = 1'b0;
        qk_value = '0;
        if (tag_in_range(qj_tag)) begin
            if (wb_valid && (wb_dest == qj_tag)) begin
                qj_ready = 1'b1;
                qj_value = wb_result;
            end else if (rob_q[tag_to_idx(qj_tag)].busy && rob_q[tag_to_idx(qj_tag)].done) begin
                qj_ready = 1'b1;
                qj_value = rob_q[tag_to_idx(qj_tag)].result;
            end
        end
        if (tag_in_range(qk_tag)) begin
            if (wb_valid && (wb_dest == qk_tag)) begin
                qk_ready = 1'b1;
                qk_value = wb_result;
            end else if (rob_q[tag_to_idx(qk_tag)].busy && rob_q[tag_to_idx(qk_tag)].done) begin
                qk_ready = 1'b1;
                qk_value = rob_q[tag_to_idx(qk_tag)].result;
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            for (int unsigned i = 0; i < ROB_SIZE; i++) begin
                rob_q[IDXW'(i)] <= '0;
            end
        end else if (flush_pipeline) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            for (int unsigned i = 0; i < ROB_SIZE; i++) begin
                rob_q[IDXW'(i)] <= '0;
            end
        end else begin
            // A pending entry is never the head being committed nor the tail being allocated
            if (wb_hit) begin
                rob_q[wb_idx].done      <= 1'b1;
                rob_q[wb_idx].result    <= wb_result;
                rob_q[wb_idx].npc       <= wb_npc;
                rob_q[wb_idx].pc_change <= wb_pc_change;
                rob_q[wb_idx].csr_wen   <= wb_csr_wen;
                rob_q[wb_idx].csr_addr  <= wb_csr_addr;
                rob_q[wb_idx].csr_wdata <= wb_csr_wdata;
                rob_q[wb_idx].ecall     <= wb_ecall;
                rob_q[wb_idx].mret      <= wb_mret;
                rob_q[wb_idx].ebreak    <= wb_ebreak;
            end
            if (commit_valid) begin
                rob_q[head_q] <= '0;
                head_q        <= head_q + IDXW'(1);
            end
            if (alloc_fire) begin
                rob_q[tail_q].busy <= 1'b1;
                rob_q[tail_q].done <= 1'b0;
                rob_q[tail_q].rd   <= alloc_rd;
                rob_q[tail_q].pc   <= alloc_pc;
                tail_q             <= tail_q + IDXW'(1);
            end
            case ({alloc_fire, commit_valid})
                2'b10:   count_q <= count_q + CNTW'(1);
                2'b01:   count_q <= count_q - CNTW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: tb/tb_ysyx_rob.sv
// Directed and randomized bench for ysyx_rob against a program-order queue model.
module tb_ysyx_rob;
    import ysyx_rob_pkg::*;

    localparam int RS = int'(ROB_SIZE);

    logic            clock;
    logic            reset;
    logic            alloc_valid;
    logic [4:0]      alloc_rd;
    logic [XLEN-1:0] alloc_pc;
    logic            alloc_ready;
    logic [TAGW-1:0] alloc_tag;
    logic            wb_valid;
    logic [TAGW-1:0] wb_dest;
    logic [XLEN-1:0] wb_result;
    logic [XLEN-1:0] wb_npc;
    logic            wb_pc_change;
    logic            wb_ebreak;
    logic            wb_ecall;
    logic            wb_mret;
    logic            wb_csr_wen;
    logic [11:0]     wb_csr_addr;
    logic [XLEN-1:0] wb_csr_wdata;
    logic [TAGW-1:0] qj_tag;
    logic [TAGW-1:0] qk_tag;
    logic            qj_ready;
    logic            qk_ready;
    logic [XLEN-1:0] qj_value;
    logic [XLEN-1:0] qk_value;
    logic            commit_valid;
    logic [4:0]      commit_rd;
    logic [XLEN-1:0] commit_pc;
    logic [XLEN-1:0] commit_result;
    logic            commit_csr_wen;
    logic [11:0]     commit_csr_addr;
    logic [XLEN-1:0] commit_csr_wdata;
    logic            commit_ecall;
    logic            commit_mret;
    logic            commit_ebreak;
    logic            flush_pipeline;
    logic [XLEN-1:0] flush_npc;

    ysyx_rob dut (
        .clock(clock), .reset(reset),
        .alloc_valid(alloc_valid), .alloc_rd(alloc_rd), .alloc_pc(alloc_pc),
        .alloc_ready(alloc_ready), .alloc_tag(alloc_tag),
        .wb_valid(wb_valid), .wb_dest(wb_dest), .wb_result(wb_result), .wb_npc(wb_npc),
        .wb_pc_change(wb_pc_change), .wb_ebreak(wb_ebreak), .wb_ecall(wb_ecall),
        .wb_mret(wb_mret), .wb_csr_wen(wb_csr_wen), .wb_csr_addr(wb_csr_addr),
        .wb_csr_wdata(wb_csr_wdata),
        .qj_tag(qj_tag), .qk_tag(qk_tag), .qj_ready(qj_ready), .qk_ready(qk_ready),
        .qj_value(qj_value), .qk_value(qk_value),
        .commit_valid(commit_valid), .commit_rd(commit_rd), .commit_pc(commit_pc),
        .commit_result(commit_result), .commit_csr_wen(commit_csr_wen),
        .commit_csr_addr(commit_csr_addr), .commit_csr_wdata(commit_csr_wdata),
        .commit_ecall(commit_ecall), .commit_mret(commit_mret), .commit_ebreak(commit_ebreak),
        .flush_pipeline(flush_pipeline), .flush_npc(flush_npc)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Reference model: in-flight instructions in program order, oldest first
    typedef struct packed {
        int          tag;
        logic        done;
        logic [4:0]  rd;
        logic [31:0] pc;
        logic [31:0] result;
        logic [31:0] npc;
        logic        pc_change;
        logic        csr_wen;
        logic [11:0] csr_addr;
        logic [31:0] csr_wdata;
        logic        ecall;
        logic        mret;
        logic        ebreak;
    } m_ent_t;

    m_ent_t m_q[$];
    int     m_tail;
    int     checks;
    int     failures;

    task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", name, obs, exp);
        end
    endtask

    function automatic int find_tag(input int tag);
        for (int i = 0; i < m_q.size(); i++) begin
            if (m_q[i].tag == tag) return i;
        end
        return -1;
    endfunction

    function automatic logic [32:0] ref_lookup(input logic [TAGW-1:0] tag);
        int idx;
        if (tag == '0) return 33'h0;
        if (wb_valid && wb_dest == tag) return {1'b1, wb_result};
        idx = find_tag(int'(tag));
        if (idx >= 0 && m_q[idx].done) return {1'b1, m_q[idx].result};
        return 33'h0;
    endfunction

    function automatic logic ref_commit();
        return (m_q.size() > 0) && m_q[0].done;
    endfunction

    function automatic logic ref_flush();
        return ref_commit() && (m_q[0].pc_change || m_q[0].ecall || m_q[0].mret);
    endfunction

    task automatic model_clear();
        m_q.delete();
        m_tail = 0;
    endtask

    task automatic check_outputs();
        logic        cv;
        logic        fl;
        logic [32:0] lj;
        logic [32:0] lk;
        cv = ref_commit();
        fl = ref_flush();
        lj = ref_lookup(qj_tag);
        lk = ref_lookup(qk_tag);
        check("alloc_ready", 32'(alloc_ready), 32'(m_q.size() != RS));
        check("alloc_tag", 32'(alloc_tag), 32'(m_tail + 1));
        check("commit_valid", 32'(commit_valid), 32'(cv));
        check("flush_pipeline", 32'(flush_pipeline), 32'(fl));
        if (cv) begin
            check("commit_rd", 32'(commit_rd), 32'(m_q[0].rd));
            check("commit_pc", commit_pc, m_q[0].pc);
            check("commit_result", commit_result, m_q[0].result);
            check("commit_csr_wen", 32'(commit_csr_wen), 32'(m_q[0].csr_wen));
            check("commit_csr_addr", 32'(commit_csr_addr), 32'(m_q[0].csr_addr));
            check("commit_csr_wdata", commit_csr_wdata, m_q[0].csr_wdata);
            check("commit_ecall", 32'(commit_ecall), 32'(m_q[0].ecall));
            check("commit_mret", 32'(commit_mret), 32'(m_q[0].mret));
            check("commit_ebreak", 32'(commit_ebreak), 32'(m_q[0].ebreak));
        end
        if (fl) check("flush_npc", flush_npc, m_q[0].npc);
        check("qj_ready", 32'(qj_ready), 32'(lj[32]));
        check("qj_value", qj_value, lj[31:0]);
        check("qk_ready", 32'(qk_ready), 32'(lk[32]));
        check("qk_value", qk_value, lk[31:0]);
    endtask

    task automatic model_edge();
        logic   cv;
        logic   fl;
        logic   accept;
        int     idx;
        m_ent_t e;
        cv     = ref_commit();
        fl     = ref_flush();
        accept = alloc_valid && (m_q.size() != RS) && !fl;
        if (wb_valid) begin
            idx = find_tag(int'(wb_dest));
            if (idx >= 0 && !m_q[idx].done) begin
                m_q[idx].done      = 1'b1;
                m_q[idx].result    = wb_result;
                m_q[idx].npc       = wb_npc;
                m_q[idx].pc_change = wb_pc_change;
                m_q[idx].csr_wen   = wb_csr_wen;
                m_q[idx].csr_addr  = wb_csr_addr;
                m_q[idx].csr_wdata = wb_csr_wdata;
                m_q[idx].ecall     = wb_ecall;
                m_q[idx].mret      = wb_mret;
                m_q[idx].ebreak    = wb_ebreak;
            end
        end
        if (fl) begin
            model_clear();
        end else begin
            if (cv) void'(m_q.pop_front());
            if (accept) begin
                e     = '0;
                e.tag = m_tail + 1;
                e.rd  = alloc_rd;
                e.pc  = alloc_pc;
                m_q.push_back(e);
                m_tail = (m_tail + 1) % RS;
            end
        end
    endtask

    task automatic idle();
        alloc_valid  = 1'b0;
        alloc_rd     = '0;
        alloc_pc     = '0;
        wb_valid     = 1'b0;
        wb_dest      = '0;
        wb_result    = '0;
        wb_npc       = '0;
        wb_pc_change = 1'b0;
        wb_ebreak    = 1'b0;
        wb_ecall     = 1'b0;
        wb_mret      = 1'b0;
        wb_csr_wen   = 1'b0;
        wb_csr_addr  = '0;
        wb_csr_wdata = '0;
        qj_tag       = '0;
        qk_tag       = '0;
    endtask

    task automatic alloc(input int rd, input logic [31:0] pc);
        alloc_valid = 1'b1;
        alloc_rd    = 5'(rd);
        alloc_pc    = pc;
    endtask

    task automatic wb(input int tag, input logic [31:0] res, input logic [31:0] npc);
        wb_valid  = 1'b1;
        wb_dest   = TAGW'(tag);
        wb_result = res;
        wb_npc    = npc;
    endtask

    // Check against the model, advance the model, then cross one clock edge
    task automatic step();
        #1;
        check_outputs();
        model_edge();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        idle();
        reset = 1'b1;
        model_clear();
        @(posedge clock);
        #1;
        reset = 1'b0;
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        m_tail   = 0;
        idle();
        reset = 1'b1;
        @(posedge clock);
        #1;
        reset = 1'b0;

        // Reset state
        #1;
        check("rst_alloc_ready", 32'(alloc_ready), 32'h1);
        check("rst_alloc_tag", 32'(alloc_tag), 32'h1);
        check("rst_commit_valid", 32'(commit_valid), 32'h0);
        check("rst_flush", 32'(flush_pipeline), 32'h0);
        check("rst_flush_npc", flush_npc, 32'h0);
        check("rst_qj_ready", 32'(qj_ready), 32'h0);

        // Async reset mid-operation
        for (int i = 0; i < 3; i++) begin
            idle(); alloc(i + 1, 32'h8000_0000 + 32'(4 * i)); step();
        end
        idle();
        #2;
        check("pre_rst_rd", 32'(commit_rd), 32'h1);
        reset = 1'b1;
        #1;
        check("async_alloc_ready", 32'(alloc_ready), 32'h1);
        check("async_alloc_tag", 32'(alloc_tag), 32'h1);
        check("async_commit_valid", 32'(commit_valid), 32'h0);
        check("async_commit_rd", 32'(commit_rd), 32'h0);
        check("async_commit_pc", commit_pc, 32'h0);
        model_clear();
        @(posedge clock);
        #1;
        reset = 1'b0;

        // In-order retire with out-of-order writebacks
        do_reset();
        for (int i = 0; i < 3; i++) begin
            idle(); alloc(i + 5, 32'h8000_0100 + 32'(4 * i));
            #1; check("io_alloc_tag", 32'(alloc_tag), 32'(i + 1));
            step();
        end
        idle(); wb(3, 32'h33, 32'h0); step();
        idle(); #1; check("io_no_commit", 32'(commit_valid), 32'h0);
        wb(1, 32'h11, 32'h0); step();
        idle(); wb(2, 32'h22, 32'h0); #1;
        check("io_c1_valid", 32'(commit_valid), 32'h1);
        check("io_c1_result", commit_result, 32'h11);
        step();
        idle(); #1;
        check("io_c2_valid", 32'(commit_valid), 32'h1);
        check("io_c2_result", commit_result, 32'h22);
        step();
        idle(); #1;
        check("io_c3_valid", 32'(commit_valid), 32'h1);
        check("io_c3_result", commit_result, 32'h33);
        step();
        idle(); #1; check("io_empty", 32'(commit_valid), 32'h0);

        // Full and wrap
        do_reset();
        for (int i = 0; i < 4; i++) begin
            idle(); alloc(i + 1, 32'h100 + 32'(i)); step();
        end
        idle(); #1; check("full_ready", 32'(alloc_ready), 32'h0);
        alloc(9, 32'h200); wb(1, 32'h1, 32'h0); step();
        idle(); alloc(9, 32'h204); #1;
        check("full_commit_valid", 32'(commit_valid), 32'h1);
        check("full_commit_ready", 32'(alloc_ready), 32'h0);
        step();
        idle(); alloc(10, 32'h208); #1;
        check("wrap_ready", 32'(alloc_ready), 32'h1);
        check("wrap_tag", 32'(alloc_tag), 32'h1);
        step();

        // Redirect flush
        do_reset();
        idle(); alloc(1, 32'h8000_0000); step();
        idle(); alloc(2, 32'h8000_0004); step();
        idle(); wb(1, 32'h7, 32'h8000_0100); wb_pc_change = 1'b1; step();
        idle(); alloc(3, 32'h8000_0008); #1;
        check("rd_commit_valid", 32'(commit_valid), 32'h1);
        check("rd_flush", 32'(flush_pipeline), 32'h1);
        check("rd_flush_npc", flush_npc, 32'h8000_0100);
        step();
        idle(); #1;
        check("rd_after_tag", 32'(alloc_tag), 32'h1);
        check("rd_after_ready", 32'(alloc_ready), 32'h1);
        check("rd_after_commit", 32'(commit_valid), 32'h0);
        step();

        // Lookup bypass and storage
        do_reset();
        idle(); alloc(1, 32'h10); step();
        idle(); alloc(2, 32'h14); step();
        idle(); wb(2, 32'hABCD, 32'h18); qj_tag = TAGW'(2); qk_tag = '0; #1;
        check("lk_byp_ready", 32'(qj_ready), 32'h1);
        check("lk_byp_value", qj_value, 32'hABCD);
        check("lk_tag0_ready", 32'(qk_ready), 32'h0);
        step();
        idle(); qj_tag = TAGW'(2); #1;
        check("lk_store_ready", 32'(qj_ready), 32'h1);
        check("lk_store_value", qj_value, 32'hABCD);
        step();

        // CSR commit, then ecall redirect, then ignored writeback
        idle(); wb(1, 32'h0, 32'h14); wb_csr_wen = 1'b1; wb_csr_addr = 12'h305;
        wb_csr_wdata = 32'h8000_0000; alloc(3, 32'h18); step();
        idle(); #1;
        check("csr_commit_valid", 32'(commit_valid), 32'h1);
        check("csr_wen", 32'(commit_csr_wen), 32'h1);
        check("csr_addr", 32'(commit_csr_addr), 32'h305);
        check("csr_wdata", commit_csr_wdata, 32'h8000_0000);
        step();
        idle(); wb(3, 32'h0, 32'h8000_0004); wb_ecall = 1'b1; step();
        idle(); #1;
        check("ecall_commit", 32'(commit_ecall), 32'h1);
        check("ecall_flush", 32'(flush_pipeline), 32'h1);
        check("ecall_npc", flush_npc, 32'h8000_0004);
        step();
        idle(); wb(2, 32'h5555, 32'h0); step();
        idle(); qj_tag = TAGW'(2); #1;
        check("nb_qj_ready", 32'(qj_ready), 32'h0);
        check("nb_commit", 32'(commit_valid), 32'h0);
        step();

        // Randomized traffic against the model
        do_reset();
        for (int n = 0; n < 600; n++) begin
            idle();
            alloc_valid  = ($urandom_range(0, 2) != 0);
            alloc_rd     = 5'($urandom);
            alloc_pc     = $urandom;
            wb_valid     = ($urandom_range(0, 3) != 0);
            wb_dest      = TAGW'($urandom_range(0, RS));
            wb_result    = $urandom;
            wb_npc       = $urandom;
            wb_pc_change = ($urandom_range(0, 15) == 0);
            wb_ecall     = ($urandom_range(0, 31) == 0);
            wb_mret      = ($urandom_range(0, 31) == 0);
            wb_ebreak    = ($urandom_range(0, 7) == 0);
            wb_csr_wen   = ($urandom_range(0, 3) == 0);
            wb_csr_addr  = 12'($urandom);
            wb_csr_wdata = $urandom;
            qj_tag       = TAGW'($urandom_range(0, RS));
            qk_tag       = TAGW'($urandom_range(0, RS));
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ysyx_rob.md
Name: ysyx_rob

Overview:
- In-order reorder buffer directly downstream of the execute stage's reservation stations.
- Allocates a destination tag per dispatched instruction (IDU side) and captures out-of-order writebacks from the execute stage.
- Exposes completed-but-uncommitted results for operand lookup.
- Retires entries strictly in program order, driving the commit bus (register file, CSR unit) and the pipeline flush on redirect.

Parameters:
- XLEN, 32, datapath width.
- ROB_SIZE, 4, number of entries; must be a power of 2, at least 2.
- TAGW, $clog2(ROB_SIZE)+1, tag width; tag 0 means "no dependency", tags 1..ROB_SIZE map to entries 0..ROB_SIZE-1.

Ports:
- clock  in  1  clock
- reset  in  1  asynchronous, active-high reset
- alloc_valid  in  1  IDU dispatches one instruction
- alloc_rd  in  5  architectural destination register (0 = none)
- alloc_pc  in  XLEN  instruction PC
- alloc_ready  out  1  entry available
- alloc_tag  out  TAGW  tag granted to this dispatch (tail index + 1)
- wb_valid  in  1  execute-stage writeback
- wb_dest  in  TAGW  tag being completed
- wb_result  in  XLEN  result value
- wb_npc  in  XLEN  resolved next PC
- wb_pc_change  in  1  redirect required
- wb_ebreak, wb_ecall, wb_mret, wb_csr_wen  in  1 each  side-effect flags
- wb_csr_addr  in  12  CSR address
- wb_csr_wdata  in  XLEN  CSR write data
- qj_tag, qk_tag  in  TAGW  operand lookup tags
- qj_ready, qk_ready  out  1  value available for the tag
- qj_value, qk_value  out  XLEN  forwarded value
- commit_valid  out  1  head entry retiring this cycle
- commit_rd, commit_pc, commit_result  out  5/XLEN/XLEN  retiring instruction
- commit_csr_wen, commit_csr_addr, commit_csr_wdata, commit_ecall, commit_mret, commit_ebreak  out  as wb_*  CSR/trap commit
- flush_pipeline  out  1  redirect: flush all younger state
- flush_npc  out  XLEN  redirect target

Behaviour:
- Reset (async, active-high): head=0, tail=0, count=0, all busy/done cleared. All outputs 0 except alloc_ready=1 and alloc_tag=1.
- State per entry: busy, done, rd, pc, result, npc, pc_change, csr fields, trap flags.
- Allocate:
  - alloc_ready = (count != ROB_SIZE); combinational, independent of alloc_valid.
  - On alloc_valid && alloc_ready && !flush_pipeline: tail entry gets busy=1, done=0, rd, pc; tail increments mod ROB_SIZE.
- Writeback:
  - On wb_valid with wb_dest != 0 and entry (wb_dest-1) busy && !done: store all wb_* fields, set done=1 at the clock edge.
  - Writeback to tag 0, a non-busy entry, or an already-done entry is ignored.
- Commit (combinational from head state):
  - commit_valid = busy[head] && done[head]; commit_* mirror the head entry.
  - At the edge: clear head entry, head increments mod ROB_SIZE.
  - Minimum latency: writeback at cycle n, commit_valid at cycle n+1.
  - One commit per cycle.
- Flush:
  - flush_pipeline = commit_valid && (pc_change || ecall || mret) of head; flush_npc = head npc.
  - The same cycle still commits the head (commit_valid=1).
  - At the edge: all entries cleared, head=tail=count=0; a same-cycle alloc is dropped.
- count update: +1 on accepted alloc, -1 on commit, unchanged when both; flush overrides to 0.
- Full: alloc_ready=0 even if the head commits this cycle (no same-cycle reuse).
- Lookup:
  - q*_ready=1 when tag != 0 and entry busy && done (value = stored result), or wb_valid && wb_dest == tag (value = wb_result, bypass).
  - Tag 0 gives ready=0, value=0.
- ebreak: commit_ebreak pulses with commit; no internal halt.
- Pointer wrap: head/tail are $clog2(ROB_SIZE) bits and wrap naturally; full vs empty is distinguished by count.

Decomposition:
- Shared package holds:
  - ROB_SIZE default and TAGW constant.
  - rob_entry_t packed struct {busy, done, rd, pc, result, npc, pc_change, csr_wen, csr_addr, csr_wdata, ecall, mret, ebreak}.
  - tag-to-index helper function.
- No sub-module: entry array plus pointer logic fits in one module (~200 lines).

Test Plan:
- Reset mid-operation: 3 entries allocated, then reset asserted async -> all outputs drop without a clock edge; alloc_ready=1, alloc_tag=1, commit_valid=0.
- In-order retire: alloc tags 1,2,3; wb tag3 (result 0x33), then tag1 (0x11), then tag2 (0x22) -> commits in order 0x11, 0x22, 0x33, each one cycle after its enabling writeback; tag3 commits the cycle after tag2.
- Full and wrap, ROB_SIZE=4:
  - Four allocs -> alloc_ready=0.
  - Commit tag1 -> alloc_ready=1 next cycle.
  - Next alloc_tag=1 (wrapped); alloc at full with a same-cycle commit is not accepted.
- Redirect: tags 1,2 allocated; wb tag1 with pc_change=1, npc=0x80000100 -> next cycle commit_valid=1, flush_pipeline=1, flush_npc=0x80000100; a same-cycle alloc is dropped; afterwards count=0, alloc_tag=1.
- Lookup bypass: qj_tag=2 while wb_dest=2, result 0xABCD -> qj_ready=1, qj_value=0xABCD same cycle; next cycle still ready from storage; qk_tag=0 -> qk_ready=0.
- CSR/ecall commit: wb with csr_wen=1, addr 0x305, wdata 0x80000000 -> commit_csr_* match on commit; ecall entry commits with flush_pipeline=1, flush_npc=wb_npc; writeback to a non-busy tag leaves state unchanged.
